// File: rtl/wb_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_if
// Purpose  : Wishbone pipelined-mode bus bundle shared by initiators and
//            targets. Carries the bus clock and reset alongside the bus.
// Ports    : clk, rst        - bus clock and asynchronous active-high reset
//            cyc, stb, we    - cycle, strobe and write-enable (initiator)
//            adr, sel, dat_i - address, byte select, write data (initiator)
//            dat_o           - read data (target)
//            ack, stall, err - handshake and error (target)
// Revision : 1.0 - initial release
// ============================================================================
interface wb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        input  clk, rst, dat_o, ack, stall, err,
        output cyc, stb, we, adr, sel, dat_i
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_i,
        output dat_o, ack, stall, err
    );
endinterface
`default_nettype wire

// File: rtl/wb_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_copy_master
// Purpose  : Wishbone pipelined initiator that copies a block of 32-bit words
//            from a source range to a destination range, one single read
//            followed by one single write per word.
// Ports    : wb       - Wishbone master port (clock/reset carried inside)
//            start    - one-cycle request, samples src_addr/dst_addr/len
//            src_addr - source byte address (bits [1:0] ignored)
//            dst_addr - destination byte address (bits [1:0] ignored)
//            len      - number of words to copy (0 = complete immediately)
//            busy     - high while a copy is in progress
//            done     - one-cycle pulse on completion or abort
//            error    - sticky bus-error flag, cleared by an accepted start
// Revision : 1.0 - initial release
// ============================================================================
module wb_copy_master #(
    parameter int LEN_WIDTH = 16
) (
    wb_if.master                 wb,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_req  = 3'd1;
    localparam logic [2:0] c_st_rd_wait = 3'd2;
    localparam logic [2:0] c_st_wr_req  = 3'd3;
    localparam logic [2:0] c_st_wr_wait = 3'd4;

    logic [2:0]           r_state;
    logic [29:0]          r_src_ptr;
    logic [29:0]          r_dst_ptr;
    logic [LEN_WIDTH-1:0] r_count;
    logic [31:0]          r_rdata;
    logic                 r_cyc;
    logic                 r_stb;
    logic                 r_we;
    logic [31:0]          r_adr;
    logic [3:0]           r_sel;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_in_wait;
    logic [29:0]          w_src_next;
    logic [29:0]          w_dst_next;
    logic                 w_unused_addr_bits;

    // Response inputs are only meaningful while a request is outstanding.
    assign w_in_wait  = (r_state == c_st_rd_wait) || (r_state == c_st_wr_wait);
    // Word pointers wrap naturally modulo 2^30.
    assign w_src_next = r_src_ptr + 30'd1;
    assign w_dst_next = r_dst_ptr + 30'd1;

    // Byte-offset bits are not part of the word address.
    assign w_unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            r_state   <= c_st_idle;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_count   <= '0;
            r_rdata   <= '0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_in_wait && wb.err) begin
                // Bus error beats ack: abandon the rest of the block.
                r_state <= c_st_idle;
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_we    <= 1'b0;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
                r_done  <= 1'b1;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start) begin
                            r_error <= 1'b0;
                            if (len != '0) begin
                                r_src_ptr <= src_addr[31:2];
                                r_dst_ptr <= dst_addr[31:2];
                                r_count   <= len;
                                r_cyc     <= 1'b1;
                                r_stb     <= 1'b1;
                                r_we      <= 1'b0;
                                r_adr     <= {src_addr[31:2], 2'b00};
                                r_sel     <= 4'hF;
                                r_busy    <= 1'b1;
                                r_state   <= c_st_rd_req;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    c_st_rd_req: begin
                        if (!wb.stall) begin
                            r_stb   <= 1'b0;
                            r_state <= c_st_rd_wait;
                        end
                    end
                    c_st_rd_wait: begin
                        if (wb.ack) begin
                            r_rdata <= wb.dat_o;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b1;
                            r_adr   <= {r_dst_ptr, 2'b00};
                            r_state <= c_st_wr_req;
                        end
                    end
                    c_st_wr_req: begin
                        if (!wb.stall) begin
                            r_stb   <= 1'b0;
                            r_state <= c_st_wr_wait;
                        end
                    end
                    c_st_wr_wait: begin
                        if (wb.ack) begin
                            r_src_ptr <= w_src_next;
                            r_dst_ptr <= w_dst_next;
                            r_count   <= r_count - LEN_WIDTH'(1);
                            if (r_count == LEN_WIDTH'(1)) begin
                                r_cyc   <= 1'b0;
                                r_we    <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= c_st_idle;
                            end else begin
                                // cyc stays high straight into the next read.
                                r_stb   <= 1'b1;
                                r_we    <= 1'b0;
                                r_adr   <= {w_src_next, 2'b00};
                                r_state <= c_st_rd_req;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wb.cyc   = r_cyc;
    assign wb.stb   = r_stb;
    assign wb.we    = r_we;
    assign wb.adr   = r_adr;
    assign wb.sel   = r_sel;
    assign wb.dat_i = r_rdata;

    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_wb_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_copy_master
// Purpose  : Self-checking bench for wb_copy_master. A behavioural Wishbone
//            target with configurable stall and error injection serves a
//            4096-word memory; a word-array reference model predicts memory
//            contents, completion time and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_copy_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_if bus (.clk(clk), .rst(rst));

    wb_copy_master dut (
        .wb       (bus),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    // ---------------- behavioural Wishbone target ----------------
    logic [31:0] mem   [0:4095];
    logic [31:0] model [0:4095];
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];
    int          wait_cnt = 0;
    int          stall_cfg = 0;
    int          wr_cnt = 0;
    int          err_at = 0;
    logic        poke_en = 1'b0;
    logic [11:0] poke_idx = '0;
    logic [31:0] poke_data = '0;

    assign bus.stall = bus.stb && (wait_cnt < stall_cfg);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.dat_o <= '0;
            wait_cnt  <= 0;
        end else begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            if (poke_en) mem[poke_idx] <= poke_data;
            if (bus.cyc && bus.stb) begin
                if (bus.stall) begin
                    wait_cnt <= wait_cnt + 1;
                end else begin
                    wait_cnt <= 0;
                    if (bus.we) begin
                        wr_log.push_back(bus.adr);
                        wr_cnt <= wr_cnt + 1;
                        if (wr_cnt + 1 == err_at) bus.err <= 1'b1;
                        else begin
                            mem[bus.adr[13:2]] <= bus.dat_i;
                            bus.ack <= 1'b1;
                        end
                    end else begin
                        rd_log.push_back(bus.adr);
                        bus.dat_o <= mem[bus.adr[13:2]];
                        bus.ack   <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus-rule monitor (between edges) ----------------
    logic        hold_v = 1'b0;
    logic [31:0] hold_adr, hold_dat;
    logic        hold_we;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else if (bus.stb) begin
            if (hold_v) begin
                check("stall_hold_adr", bus.adr, hold_adr);
                check("stall_hold_dat", bus.dat_i, hold_dat);
                check("stall_hold_we", 32'(bus.we), 32'(hold_we));
            end
            check("sel_full", 32'(bus.sel), 32'hF);
            check("stb_needs_cyc", 32'(bus.cyc), 32'd1);
            hold_adr = bus.adr;
            hold_dat = bus.dat_i;
            hold_we  = bus.we;
            hold_v   = bus.stall;
        end else begin
            hold_v = 1'b0;
        end
        if (bus.cyc) check("cyc_needs_busy", 32'(busy), 32'd1);
    end

    // ---------------- reference model helpers ----------------
    task automatic poke(input logic [11:0] idx, input logic [31:0] data);
        @(negedge clk);
        poke_idx  = idx;
        poke_data = data;
        poke_en   = 1'b1;
        model[idx] = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Word-by-word copy: each destination word gets the source word read
    // after all earlier words have been written.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [29:0] sp, dp;
        sp = s[31:2];
        dp = d[31:2];
        for (int i = 0; i < n; i++) begin
            model[dp[11:0]] = model[sp[11:0]];
            sp = sp + 30'd1;
            dp = dp + 30'd1;
        end
    endtask

    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== model[i]) bad++;
        check({tag, ":mem_words_wrong"}, 32'(bad), 32'd0);
    endtask

    int t_cycles, t_cyc_cnt, t_busy_cnt;
    bit t_done;

    // Pulse start, then count negedges until done (1 = visible right after
    // the edge that sampled start). inj_at injects a second start mid-copy.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int inj_at);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = 16'(n);
        start    = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        t_cycles   = 1;
        t_cyc_cnt  = 0;
        t_busy_cnt = 0;
        t_done     = 1'b0;
        while (!t_done && t_cycles <= 3000) begin
            if (bus.cyc) t_cyc_cnt++;
            if (busy) t_busy_cnt++;
            if (done) t_done = 1'b1;
            else begin
                if (t_cycles == inj_at) begin
                    src_addr = 32'h1F00;
                    dst_addr = 32'h1E00;
                    len      = 16'd5;
                    start    = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                t_cycles++;
            end
        end
        start = 1'b0;
    endtask

    task automatic copy_and_check(input string tag, input logic [31:0] s, input logic [31:0] d,
                                  input int n, input int stall, input int inj_at);
        stall_cfg = stall;
        run_copy(s, d, n, inj_at);
        check({tag, ":done_seen"}, 32'(t_done), 32'd1);
        check({tag, ":cycles"}, 32'(t_cycles), 32'((4 + 2 * stall) * n + 1));
        check({tag, ":error"}, 32'(error), 32'd0);
        model_copy(s, d, n);
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ":busy_after"}, 32'(busy), 32'd0);
        mem_compare(tag);
        stall_cfg = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int base, k, dcount;
        logic [31:0] s, d;
        int n, st;

        for (int i = 0; i < 4096; i++) begin
            mem[i]   = '0;
            model[i] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst:cyc", 32'(bus.cyc), 32'd0);
        check("rst:stb", 32'(bus.stb), 32'd0);
        check("rst:we", 32'(bus.we), 32'd0);
        check("rst:adr", bus.adr, 32'd0);
        check("rst:sel", 32'(bus.sel), 32'd0);
        check("rst:dat_i", bus.dat_i, 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:error", 32'(error), 32'd0);
        rst = 1'b0;

        // Basic 4-word copy, zero-wait target
        poke(12'd0, 32'h11111111);
        poke(12'd1, 32'h22222222);
        poke(12'd2, 32'h33333333);
        poke(12'd3, 32'h44444444);
        copy_and_check("basic", 32'h0, 32'h40, 4, 0, -1);
        check("basic:cyc_cycles", 32'(t_cyc_cnt), 32'd16);
        check("basic:busy_cycles", 32'(t_busy_cnt), 32'd16);

        // Same copy through a target stalling 3 cycles per request
        copy_and_check("stall3", 32'h0, 32'h80, 4, 3, -1);

        // len = 0: no bus activity, done one cycle later
        copy_and_check("len0", 32'h0, 32'h100, 0, 0, -1);
        check("len0:cyc_cycles", 32'(t_cyc_cnt), 32'd0);
        check("len0:busy_cycles", 32'(t_busy_cnt), 32'd0);

        // Error on the second write
        err_at = wr_cnt + 2;
        run_copy(32'h0, 32'h100, 4, -1);
        check("err:done_seen", 32'(t_done), 32'd1);
        check("err:cycles", 32'(t_cycles), 32'd9);
        check("err:error", 32'(error), 32'd1);
        check("err:cyc_dropped", 32'(bus.cyc), 32'd0);
        check("err:busy_dropped", 32'(busy), 32'd0);
        model_copy(32'h0, 32'h100, 1);
        mem_compare("err");
        err_at = 0;
        repeat (3) @(negedge clk);
        check("err:sticky", 32'(error), 32'd1);
        copy_and_check("err_clear", 32'h8, 32'h180, 1, 0, -1);

        // Source address wrap at the top of the address space
        poke(12'hFFF, 32'hCAFEF00D);
        base = rd_log.size();
        copy_and_check("wrap", 32'hFFFFFFFC, 32'h200, 2, 0, -1);
        check("wrap:rd_count", 32'(rd_log.size() - base), 32'd2);
        check("wrap:rd_adr0", rd_log[base], 32'hFFFFFFFC);
        check("wrap:rd_adr1", rd_log[base + 1], 32'h00000000);

        // Byte-offset bits ignored on both sides
        base = rd_log.size();
        k = wr_log.size();
        copy_and_check("lowbits", 32'h3, 32'h301, 1, 0, -1);
        check("lowbits:rd_adr", rd_log[base], 32'h0);
        check("lowbits:wr_adr", wr_log[k], 32'h300);

        // Reset while waiting for a write ack
        for (int i = 0; i < 3; i++) poke(12'h400 + 12'(i), $urandom);
        @(negedge clk);
        src_addr = 32'h1000;
        dst_addr = 32'h1100;
        len      = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(bus.cyc && !bus.stb && bus.we) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid:reached_wr_wait", 32'(k < 100), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid:cyc", 32'(bus.cyc), 32'd0);
        check("rst_mid:stb", 32'(bus.stb), 32'd0);
        check("rst_mid:busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("rst_mid:no_done", 32'(dcount), 32'd0);
        model_copy(32'h1000, 32'h1100, 1);
        mem_compare("rst_mid");
        copy_and_check("after_rst", 32'h1000, 32'h1100, 3, 0, -1);

        // A start while busy is ignored
        copy_and_check("busy_start", 32'h1000, 32'h1200, 3, 0, 4);

        // Randomized copies
        for (int it = 0; it < 6; it++) begin
            n  = int'($urandom_range(1, 6));
            st = int'($urandom_range(0, 2));
            s  = (32'($urandom_range(0, 2000)) << 2) | 32'($urandom_range(0, 3));
            d  = (32'($urandom_range(2100, 4000)) << 2) | 32'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) poke(12'(s[31:2] + 32'(i)), $urandom);
            copy_and_check($sformatf("rand%0d", it), s, d, n, st, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
